alu_operand_collector: RTL and testbench

//  Parametrised front-end ahead of the ALU core. Gathers OPA/OPB that arrive in separate cycles per INP_VALID.

---
 rtl/alu_operand_collector.sv | 193 +++++++++++++++++++
 tb/tb_alu_operand_collector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_collector.sv
// ============================================================================
//  Module   : alu_operand_collector
//  Purpose  : Gathers split OPA/OPB beats into one complete ALU op, issues it
//             over valid/ready, and drops a half-collected op after TIMEOUT.
//  Options  : ALU_COLLECT_STATS_EN adds saturating issued/timeout counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_operand_collector #(
   parameter int          N         = 8,
   parameter int          M         = 4,
   parameter int          TIMEOUT   = 16,
   parameter logic [15:0] ARITH_2OP = 16'h070F,
   parameter logic [15:0] LOGIC_2OP = 16'h303F
`ifdef ALU_COLLECT_STATS_EN
   ,
   parameter int          CNT_W     = 16
`endif
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CE,
   input  logic [N-1:0]     IN_OPA,
   input  logic [N-1:0]     IN_OPB,
   input  logic [1:0]       IN_INP_VALID,
   input  logic [M-1:0]     IN_CMD,
   input  logic             IN_MODE,
   input  logic             IN_CIN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [N-1:0]     OUT_OPA,
   output logic [N-1:0]     OUT_OPB,
   output logic [M-1:0]     OUT_CMD,
   output logic             OUT_MODE,
   output logic             OUT_CIN,
   output logic             OUT_TIMEOUT,
   output logic             BUSY
`ifdef ALU_COLLECT_STATS_EN
   ,
   output logic [CNT_W-1:0] STAT_ISSUED,
   output logic [CNT_W-1:0] STAT_TIMEOUTS
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WAIT_B = 2'd1;
   localparam logic [1:0] WAIT_A = 2'd2;
   localparam logic [1:0] HOLD   = 2'd3;

   localparam int          TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [N-1:0]  opa_q, opa_d, opb_q, opb_d;
   logic [M-1:0]  cmd_q, cmd_d;
   logic          mode_q, mode_d, cin_q, cin_d;
   logic          timeout_q, timeout_d;
   logic          issue_evt, to_evt;

   // Commands outside the 16-entry tables never wait for a second operand.
   function automatic logic needs_two(input logic mode, input logic [M-1:0] cmd);
      logic [31:0] idx;
      idx = 32'(cmd);
      if (idx < 32'd16)
         return mode ? ARITH_2OP[idx[3:0]] : LOGIC_2OP[idx[3:0]];
      return 1'b0;
   endfunction

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      cmd_d     = cmd_q;
      mode_d    = mode_q;
      cin_d     = cin_q;
      timeout_d = timeout_q;
      issue_evt = 1'b0;
      to_evt    = 1'b0;
      if (CE) begin
         timeout_d = 1'b0;
         case (state_q)
            WAIT_B: begin
               if (IN_INP_VALID[1]) begin
                  opb_d   = IN_OPB;
                  state_d = HOLD;
               end else if (timer_q == T_LAST) begin
                  state_d   = IDLE;
                  timer_d   = '0;
                  timeout_d = 1'b1;
                  to_evt    = 1'b1;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            WAIT_A: begin
               if (IN_INP_VALID[0]) begin
                  opa_d   = IN_OPA;
                  state_d = HOLD;
               end else if (timer_q == T_LAST) begin
                  state_d   = IDLE;
                  timer_d   = '0;
                  timeout_d = 1'b1;
                  to_evt    = 1'b1;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: begin
               // IDLE, or HOLD whose op is taken this cycle: new op may load now.
               if (state_q == IDLE || OUT_READY) begin
                  issue_evt = (state_q == HOLD);
                  state_d   = IDLE;
                  timer_d   = '0;
                  if (IN_INP_VALID != 2'b00) begin
                     cmd_d   = IN_CMD;
                     mode_d  = IN_MODE;
                     cin_d   = IN_CIN;
                     state_d = HOLD;
                  end
                  if (IN_INP_VALID[0]) opa_d = IN_OPA;
                  if (IN_INP_VALID[1]) opb_d = IN_OPB;
                  if (IN_INP_VALID == 2'b01 && needs_two(IN_MODE, IN_CMD)) state_d = WAIT_B;
                  if (IN_INP_VALID == 2'b10 && needs_two(IN_MODE, IN_CMD)) state_d = WAIT_A;
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         cmd_q     <= '0;
         mode_q    <= 1'b0;
         cin_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         cmd_q     <= cmd_d;
         mode_q    <= mode_d;
         cin_q     <= cin_d;
         timeout_q <= timeout_d;
      end
   end

   assign OUT_VALID   = (state_q == HOLD);
   assign BUSY        = (state_q != IDLE);
   assign OUT_OPA     = opa_q;
   assign OUT_OPB     = opb_q;
   assign OUT_CMD     = cmd_q;
   assign OUT_MODE    = mode_q;
   assign OUT_CIN     = cin_q;
   assign OUT_TIMEOUT = timeout_q;

`ifdef ALU_COLLECT_STATS_EN
   logic [CNT_W-1:0] issued_q, issued_d, tos_q, tos_d;

   always_comb begin
      issued_d = issued_q;
      tos_d    = tos_q;
      if (issue_evt && issued_q != '1) issued_d = issued_q + 1'b1;
      if (to_evt && tos_q != '1)       tos_d    = tos_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         issued_q <= '0;
         tos_q    <= '0;
      end else begin
         issued_q <= issued_d;
         tos_q    <= tos_d;
      end
   end

   assign STAT_ISSUED   = issued_q;
   assign STAT_TIMEOUTS = tos_q;
`else
   logic unused_evt;
   assign unused_evt = issue_evt ^ to_evt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_collector.sv
// ============================================================================
//  Module   : tb_alu_operand_collector
//  Purpose  : Directed vectors with hand-computed expectations for the
//             operand collector (stats checked when ALU_COLLECT_STATS_EN).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_collector;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CE = 1'b1;
   logic [7:0] IN_OPA = '0, IN_OPB = '0;
   logic [1:0] IN_INP_VALID = '0;
   logic [3:0] IN_CMD = '0;
   logic       IN_MODE = 1'b0, IN_CIN = 1'b0;
   logic       OUT_READY = 1'b1;
   logic       OUT_VALID, OUT_MODE, OUT_CIN, OUT_TIMEOUT, BUSY;
   logic [7:0] OUT_OPA, OUT_OPB;
   logic [3:0] OUT_CMD;
`ifdef ALU_COLLECT_STATS_EN
   logic [15:0] STAT_ISSUED, STAT_TIMEOUTS;
`endif

   int n_vec = 0;
   int n_err = 0;

   alu_operand_collector dut (
      .CLK(CLK), .RST(RST), .CE(CE),
      .IN_OPA(IN_OPA), .IN_OPB(IN_OPB), .IN_INP_VALID(IN_INP_VALID),
      .IN_CMD(IN_CMD), .IN_MODE(IN_MODE), .IN_CIN(IN_CIN),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_OPA(OUT_OPA), .OUT_OPB(OUT_OPB), .OUT_CMD(OUT_CMD),
      .OUT_MODE(OUT_MODE), .OUT_CIN(OUT_CIN),
      .OUT_TIMEOUT(OUT_TIMEOUT), .BUSY(BUSY)
`ifdef ALU_COLLECT_STATS_EN
      , .STAT_ISSUED(STAT_ISSUED), .STAT_TIMEOUTS(STAT_TIMEOUTS)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1ns after it.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic drive(input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] cmd, input logic mode);
      IN_INP_VALID = iv;
      IN_OPA       = a;
      IN_OPB       = b;
      IN_CMD       = cmd;
      IN_MODE      = mode;
   endtask

   logic saw_to;

   initial begin
      tick(2);
      check("rst_valid", 32'(OUT_VALID), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_timeout", 32'(OUT_TIMEOUT), 0);
      check("rst_opa", 32'(OUT_OPA), 0);
      check("rst_opb", 32'(OUT_OPB), 0);
      RST = 1'b0;

      // 1. full op
      drive(2'b11, 8'h05, 8'h03, 4'd0, 1'b1);
      tick();
      check("full_valid", 32'(OUT_VALID), 1);
      check("full_opa", 32'(OUT_OPA), 32'h05);
      check("full_opb", 32'(OUT_OPB), 32'h03);
      drive(2'b00, 8'h00, 8'h00, 4'd0, 1'b0);
      tick();
      check("full_busy_after", 32'(BUSY), 0);

      // 2. split op, second beat's CMD must be ignored
      drive(2'b01, 8'h20, 8'h00, 4'd0, 1'b1);
      tick();
      check("split_wait_busy", 32'(BUSY), 1);
      check("split_wait_valid", 32'(OUT_VALID), 0);
      drive(2'b00, 8'h00, 8'h00, 4'd0, 1'b1);
      tick(4);
      drive(2'b10, 8'h00, 8'h11, 4'd9, 1'b1);
      tick();
      check("split_valid", 32'(OUT_VALID), 1);
      check("split_opa", 32'(OUT_OPA), 32'h20);
      check("split_opb", 32'(OUT_OPB), 32'h11);
      check("split_cmd", 32'(OUT_CMD), 0);
      drive(2'b00, 8'h00, 8'h00, 4'd0, 1'b0);
      tick();

      // 3a. timeout after 16 wait cycles
      drive(2'b01, 8'h0C, 8'h00, 4'd1, 1'b1);
      tick();
      drive(2'b00, 8'h00, 8'h00, 4'd0, 1'b0);
      tick(15);
      check("to_pre_pulse", 32'(OUT_TIMEOUT), 0);
      check("to_pre_busy", 32'(BUSY), 1);
      tick();
      check("to_pulse", 32'(OUT_TIMEOUT), 1);
      check("to_valid", 32'(OUT_VALID), 0);
      check("to_busy", 32'(BUSY), 0);
      tick();
      check("to_pulse_once", 32'(OUT_TIMEOUT), 0);
`ifdef ALU_COLLECT_STATS_EN
      check("stat_to_1", 32'(STAT_TIMEOUTS), 1);
`endif

      // 3b. B arrives on the last (16th) wait cycle
      drive(2'b01, 8'h0D, 8'h00, 4'd1, 1'b1);
      tick();
      drive(2'b00, 8'h00, 8'h00, 4'd0, 1'b0);
      tick(15);
      drive(2'b10, 8'h00, 8'h44, 4'd0, 1'b0);
      tick();
      check("last_valid", 32'(OUT_VALID), 1);
      check("last_timeout", 32'(OUT_TIMEOUT), 0);
      check("last_opb", 32'(OUT_OPB), 32'h44);
      check("last_cmd", 32'(OUT_CMD), 1);
      drive(2'b00, 8'h00, 8'h00, 4'd0, 1'b0);
      tick();

      // 4. single-op commands go straight to HOLD
      drive(2'b01, 8'h07, 8'h00, 4'd4, 1'b1);
      tick();
      check("single_valid", 32'(OUT_VALID), 1);
      check("single_opa", 32'(OUT_OPA), 32'h07);
      drive(2'b10, 8'h00, 8'h66, 4'd6, 1'b0);
      tick();
      check("single_logic_valid", 32'(OUT_VALID), 1);
      check("single_logic_opb", 32'(OUT_OPB), 32'h66);
      check("single_logic_cmd", 32'(OUT_CMD), 6);
      drive(2'b00, 8'h00, 8'h00, 4'd0, 1'b0);
      tick();
      check("single_idle", 32'(BUSY), 0);

      // 5. backpressure
      drive(2'b11, 8'h01, 8'h02, 4'd3, 1'b0);
      tick();
      OUT_READY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 8'hAA + 8'(i), 8'hBB, 4'd7, 1'b1);
         tick();
         check("bp_valid", 32'(OUT_VALID), 1);
         check("bp_opa", 32'(OUT_OPA), 32'h01);
         check("bp_cmd", 32'(OUT_CMD), 3);
      end
      OUT_READY = 1'b1;
      drive(2'b11, 8'h09, 8'h08, 4'd2, 1'b1);
      tick();
      check("bp_reload_valid", 32'(OUT_VALID), 1);
      check("bp_reload_opa", 32'(OUT_OPA), 32'h09);
      drive(2'b00, 8'h00, 8'h00, 4'd0, 1'b0);
      tick();
`ifdef ALU_COLLECT_STATS_EN
      check("stat_issued", 32'(STAT_ISSUED), 7);
`endif

      // 6a. CE=0 freezes the wait timer
      drive(2'b01, 8'h33, 8'h00, 4'd0, 1'b1);
      tick();
      drive(2'b00, 8'h00, 8'h00, 4'd0, 1'b0);
      tick(5);
      CE = 1'b0;
      tick(10);
      check("ce_busy", 32'(BUSY), 1);
      CE = 1'b1;
      tick(10);
      check("ce_pre_pulse", 32'(OUT_TIMEOUT), 0);
      check("ce_pre_busy", 32'(BUSY), 1);
      tick();
      check("ce_pulse", 32'(OUT_TIMEOUT), 1);
      tick();

      // 6b. reset inside WAIT_A
      drive(2'b10, 8'h00, 8'h55, 4'd0, 1'b1);
      tick();
      check("wa_busy", 32'(BUSY), 1);
      drive(2'b00, 8'h00, 8'h00, 4'd0, 1'b0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("wa_rst_busy", 32'(BUSY), 0);
      check("wa_rst_valid", 32'(OUT_VALID), 0);
      check("wa_rst_opb", 32'(OUT_OPB), 0);
`ifdef ALU_COLLECT_STATS_EN
      check("stat_rst", 32'(STAT_TIMEOUTS), 0);
`endif
      saw_to = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         saw_to = saw_to | OUT_TIMEOUT;
      end
      check("wa_rst_no_timeout", 32'(saw_to), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
